// File: rtl/perf_counter_bank.sv
// Bank of event counters with sticky overflow flags, atomic snapshot/clear,
// and a one-entry valid/ready read port onto the snapshot registers.
package perf_pkg;
    localparam int unsigned COUNTER_W = 64;
    typedef logic [COUNTER_W-1:0] counter_t;
endpackage

module perf_counter_bank #(
    parameter int unsigned NUM_CNT  = 8,
    parameter int unsigned CNT_W    = 64,
    parameter bit          SATURATE = 1'b0,
    localparam int unsigned IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_CNT-1:0] event_i,
    input  logic               cnt_en_i,
    input  logic               clear_i,
    input  logic               snapshot_i,
    input  logic               rd_req_valid_i,
    output logic               rd_req_ready_o,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic               rd_resp_valid_o,
    input  logic               rd_resp_ready_i,
    output logic [CNT_W-1:0]   rd_resp_data_o,
    output logic               rd_resp_err_o,
    output logic [NUM_CNT-1:0] ovf_o
);

    // Same shape as perf_pkg::counter_t when CNT_W is 64.
    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t               live_q [NUM_CNT];
    cnt_t               live_d [NUM_CNT];
    cnt_t               snap_q [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_q;
    logic [NUM_CNT-1:0] ovf_d;

    logic               resp_valid_q;
    cnt_t               resp_data_q;
    logic               resp_err_q;

    logic               rd_accept_c;
    logic               rd_oob_c;
    cnt_t               rd_data_c;

    // Counter next-state: increment/overflow first, clear overrides both.
    always_comb begin
        for (int k = 0; k < int'(NUM_CNT); k++) begin
            live_d[k] = live_q[k];
            ovf_d[k]  = ovf_q[k];
            if (cnt_en_i && event_i[k]) begin
                if (&live_q[k]) begin
                    ovf_d[k]  = 1'b1;
                    live_d[k] = SATURATE ? live_q[k] : '0;
                end else begin
                    live_d[k] = live_q[k] + CNT_W'(1);
                end
            end
            if (clear_i) begin
                live_d[k] = '0;
                ovf_d[k]  = 1'b0;
            end
        end
    end

    // Snapshot samples live_q, i.e. the value before this cycle's update/clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(NUM_CNT); k++) begin
                live_q[k] <= '0;
                snap_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_CNT); k++) begin
                live_q[k] <= live_d[k];
                if (snapshot_i) begin
                    snap_q[k] <= live_q[k];
                end
            end
            ovf_q <= ovf_d;
        end
    end

    assign rd_req_ready_o = !resp_valid_q || rd_resp_ready_i;
    assign rd_accept_c    = rd_req_valid_i && rd_req_ready_o;
    assign rd_oob_c       = {1'b0, rd_idx_i} >= (IDX_W + 1)'(NUM_CNT);

    always_comb begin
        rd_data_c = '0;
        for (int k = 0; k < int'(NUM_CNT); k++) begin
            if (rd_idx_i == IDX_W'(k)) begin
                rd_data_c = snap_q[k];
            end
        end
    end

    // Single-entry response register; holds until consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else if (rd_accept_c) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= rd_oob_c ? '0 : rd_data_c;
            resp_err_q   <= rd_oob_c;
        end else if (rd_resp_ready_i) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign rd_resp_valid_o = resp_valid_q;
    assign rd_resp_data_o  = resp_data_q;
    assign rd_resp_err_o   = resp_err_q;
    assign ovf_o           = ovf_q;

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CNT, default 8, number of event counters (1..64).
REQ-002 Parameter CNT_W, default 64, counter width in bits (8..64); at 64, counter type is perf_pkg::counter_t.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at overflow, 1 = hold at all-ones.
REQ-004 Derived IDX_W = max(1, clog2(NUM_CNT)).
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_i  input  1  synchronous, active-high reset.
REQ-007 event_i  input  NUM_CNT  per-counter event strobe, one increment per asserted cycle.
REQ-008 cnt_en_i  input  1  global count enable.
REQ-009 clear_i  input  1  global clear of live counters and overflow flags.
REQ-010 snapshot_i  input  1  copy all live counters into snapshot registers.
REQ-011 rd_req_valid_i  input  1  read request valid.
REQ-012 rd_req_ready_o  output  1  read request ready.
REQ-013 rd_idx_i  input  IDX_W  snapshot index to read.
REQ-014 rd_resp_valid_o  output  1  read response valid.
REQ-015 rd_resp_ready_i  input  1  read response consumed.
REQ-016 rd_resp_data_o  output  CNT_W  snapshot value.
REQ-017 rd_resp_err_o  output  1  index out of range (rd_idx_i >= NUM_CNT).
REQ-018 ovf_o  output  NUM_CNT  sticky per-counter overflow flags.

Function
REQ-019 Live counter k increments by 1 in a cycle iff cnt_en_i && event_i[k]; otherwise holds.
REQ-020 Increment from all-ones with SATURATE=0: value becomes 0, ovf_o[k] set.
REQ-021 Increment from all-ones with SATURATE=1: value stays all-ones, ovf_o[k] set.
REQ-022 ovf_o[k] remains set until clear_i or rst_i; no other event clears it.
REQ-023 clear_i: live counters and ovf_o become 0 next cycle; clear dominates a same-cycle increment and overflow.
REQ-024 snapshot_i: every snapshot register captures the live value present before this cycle's update (pre-increment, pre-clear).
REQ-025 snapshot_i with clear_i in same cycle: snapshot gets pre-clear values, live counters become 0 (atomic read-and-reset, no lost events).
REQ-026 Snapshot registers change only on snapshot_i or rst_i.
REQ-027 Response stage is a single-entry register; rd_req_ready_o = !rd_resp_valid_o || rd_resp_ready_i (combinational).
REQ-028 Request accepted when rd_req_valid_i && rd_req_ready_o; response valid the next cycle (latency 1).
REQ-029 Response data = snapshot[rd_idx_i] as held at the acceptance edge; a same-cycle snapshot_i is not visible in that response.
REQ-030 Out-of-range index: rd_resp_data_o = 0, rd_resp_err_o = 1; otherwise rd_resp_err_o = 0.
REQ-031 rd_resp_valid_o, rd_resp_data_o, rd_resp_err_o stable while rd_resp_valid_o && !rd_resp_ready_i.
REQ-032 Response cleared (valid low) after handshake with no new accepted request; back-to-back accept with rd_resp_ready_i high sustains one read per cycle.
REQ-033 Counting, clear, snapshot are independent of read handshake state.

Reset
REQ-034 rst_i high at an edge: all live counters, snapshot registers, ovf_o, rd_resp_valid_o, rd_resp_data_o, rd_resp_err_o become 0.
REQ-035 rst_i dominates clear_i, snapshot_i, events and in-flight reads; pending response is dropped.
REQ-036 rd_req_ready_o = 1 in the cycle after reset release.

Verification
REQ-037 CNT_W=8, SATURATE=0: 256 events on counter 0 with cnt_en_i=1 -> live 0, ovf_o[0]=1, other ovf bits 0.
REQ-038 CNT_W=8, SATURATE=1: 300 events on counter 2 -> value 255, ovf_o[2]=1; snapshot then read idx 2 -> data 0xFF, err 0.
REQ-039 Counter 1 at 10, event_i[1]=1 with snapshot_i=1 and clear_i=1 same cycle -> snapshot[1]=10, live 0, ovf 0; next event -> live 1.
REQ-040 Read idx 3 with rd_resp_ready_i=0 for 4 cycles -> rd_req_ready_o=0, response held; ready high -> handshake, next request accepted same cycle.
REQ-041 NUM_CNT=6, read idx 7 -> rd_resp_data_o=0, rd_resp_err_o=1, one cycle after acceptance.
REQ-042 rst_i asserted with response pending and counters nonzero -> next cycle all outputs 0, rd_req_ready_o=1; cnt_en_i=0 with events -> counters stay 0.
